// File: rtl/risc_pkg.sv
// Shared definitions for the core's load/store-multiple sequencers.
package risc_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;
   localparam int NREG_DEF   = 8;
   localparam int RIDX_W     = 3;   // log2(NREG_DEF)

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } sm_state_t;

endpackage

// File: rtl/lsb_prio_enc8.sv
// 8-bit lowest-set-bit priority encoder; bit 0 wins. Shared with the LM path.
module lsb_prio_enc8
   import risc_pkg::*;
(
   input  logic [7:0]        i_vec,
   output logic [RIDX_W-1:0] o_idx,
   output logic              o_vld
);

   // Scan from the top down so the lowest set bit is written last and wins.
   always_comb begin
      o_idx = '0;
      o_vld = |i_vec;
      for (int i = 7; i >= 0; i--) begin
         if (i_vec[i]) o_idx = RIDX_W'(i);
      end
   end

endmodule

// File: rtl/sm_store_sequencer.sv
// Store-Multiple sequencer: walks a register mask lowest-first, reading one
// register and writing it to consecutive memory addresses per set bit.
module sm_store_sequencer
   import risc_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREG   = NREG_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sm_start,
   input  logic [NREG-1:0]   imm_mask,
   input  logic [ADDR_W-1:0] base_addr,
   output logic [RIDX_W-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic              stall,
   output logic              sm_done
);

   sm_state_t         r_state, w_state_nxt;
   logic [NREG-1:0]   r_mask,  w_mask_nxt;
   logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
   logic [RIDX_W-1:0] w_idx;
   logic              w_vld;
   logic              w_issue;
   logic              w_done;
   logic              w_accept;
   logic [NREG-1:0]   w_mask_clr;

   lsb_prio_enc8 u_enc (
      .i_vec (r_mask),
      .o_idx (w_idx),
      .o_vld (w_vld)
   );

   // Remaining mask with its lowest set bit removed (the bit being written).
   assign w_mask_clr = r_mask & (r_mask - NREG'(1));

   // State, remaining mask and address counter; reset abandons any sequence.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_mask  <= '0;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_mask  <= w_mask_nxt;
         r_addr  <= w_addr_nxt;
      end
   end

   // Next-state logic; a not-ready memory simply leaves everything as is.
   always_comb begin
      w_state_nxt = r_state;
      w_mask_nxt  = r_mask;
      w_addr_nxt  = r_addr;
      w_issue     = 1'b0;
      w_done      = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (sm_start) begin
               w_accept    = 1'b1;
               w_mask_nxt  = imm_mask;
               w_addr_nxt  = base_addr;
               w_state_nxt = (imm_mask != '0) ? S_ISSUE : S_DONE;
            end
         end
         S_ISSUE: begin
            w_issue = w_vld;
            if (!w_vld) begin
               w_state_nxt = S_DONE;
            end else if (mem_ready) begin
               w_mask_nxt = w_mask_clr;
               w_addr_nxt = r_addr + ADDR_W'(1);   // wraps modulo 2^ADDR_W
               if (w_mask_clr == '0) w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign rf_raddr  = w_issue ? w_idx : '0;
   assign mem_we    = w_issue;
   assign mem_addr  = r_addr;
   assign mem_wdata = rf_rdata;
   assign sm_done   = w_done;
   assign stall     = w_accept | (r_state != S_IDLE);

endmodule

// File: doc/sm_store_sequencer.md
Name: sm_store_sequencer

Overview:
- Store-Multiple (SM) sequencer for the pipelined core. Counterpart of the Load-Multiple register-destination sequencer: LM walks an 8-bit mask and writes registers from memory; this block walks the mask and writes registers to memory.
- On a start pulse it captures the 8-bit register mask and a base address. It then issues one register-file read plus one memory write per set mask bit, in ascending register order, at consecutive addresses.
- Sits between decode/execute and the data-memory port, and stalls the upstream pipeline while active.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, register/memory data width.
- NREG, 8, number of architectural registers (mask width); register index width is log2(NREG) = 3.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sm_start  in  1  one-cycle request to begin an SM sequence.
- imm_mask  in  NREG  register mask, bit i selects Ri; sampled with sm_start.
- base_addr  in  ADDR_W  first memory address; sampled with sm_start.
- rf_raddr  out  3  register-file read index.
- rf_rdata  in  DATA_W  combinational register-file read data for rf_raddr.
- mem_addr  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data (equals rf_rdata).
- mem_we  out  1  memory write request.
- mem_ready  in  1  memory accepts the write this cycle when high with mem_we.
- stall  out  1  freeze fetch/decode.
- sm_done  out  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, on port reset_n.
- Reset (asserted at any time, including mid-sequence, takes effect asynchronously):
  - state=IDLE, remaining mask=0, address counter=0.
  - mem_we=0, sm_done=0, rf_raddr=3'b000, mem_addr=0.
  - The interrupted sequence is abandoned, with no further writes.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - sm_start=1 captures mask and address counter (=base_addr).
  - Next state is ISSUE if mask!=0, otherwise DONE.
  - sm_start is ignored in every other state.
- ISSUE:
  - rf_raddr = index of the lowest set bit of the remaining mask (bit 0 has highest priority).
  - mem_addr = address counter; mem_wdata = rf_rdata; mem_we=1.
  - On mem_ready=1: clear that mask bit and increment the address counter. If the cleared mask becomes 0, go to DONE; otherwise stay in ISSUE.
  - On mem_ready=0: hold all outputs and state unchanged, with no skip and no duplicate.
- DONE: sm_done=1 for exactly one cycle, mem_we=0, then IDLE.
- stall = sm_start_accepted | (state != IDLE). The upstream pipeline is therefore frozen from the start cycle through the DONE cycle inclusive.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFF+1 wraps to 0x0000 with no flag.
- Latency, with mem_ready tied high and N set bits:
  - sm_start in cycle 0.
  - Writes in cycles 1..N.
  - sm_done in cycle N+1 (N=0 gives sm_done in cycle 1).
- In IDLE: mem_we=0 and rf_raddr=0. mem_addr shows the counter and is don't-care for memory.

Decomposition:
- Shared package (risc_pkg): the SM state enum (IDLE/ISSUE/DONE), ADDR_W/DATA_W/NREG defaults, and the register-index width constant.
- One sub-module, lsb_prio_enc8: 8-bit lowest-set-bit priority encoder returning a 3-bit index and a valid flag. It is reused by the LM path.

Test Plan:
- Sparse mask, ready tied high: mask=8'b1000_0101, base=0x0040, R0=0x1111, R2=0x2222, R7=0x7777.
  -> Writes (0x0040,0x1111), (0x0041,0x2222), (0x0042,0x7777) in cycles 1-3; sm_done in cycle 4; stall high in cycles 0-4.
- Empty mask: mask=0x00.
  -> No mem_we; sm_done in cycle 1; stall in cycles 0-1.
- Wrap-around: mask=0xFF, base=0xFFFE.
  -> Addresses FFFE, FFFF, 0000..0005 with rf_raddr 0..7 in order; sm_done in cycle 9.
- Backpressure: mask=0x06, mem_ready low for 2 cycles on the first write.
  -> (addr=base, raddr=1) held 3 cycles, then (base+1, raddr=2); exactly two accepted writes.
- Mid-sequence reset: reset_n low asynchronously during the second write of mask=0x0F.
  -> mem_we drops immediately; after release, state is IDLE and sm_done is never pulsed. A new sm_start with mask=0x01 then completes normally.
- Start while busy: sm_start with mask=0xF0 pulsed during ISSUE of mask=0x03.
  -> Ignored; only R0 and R1 are written.
